enc_pack_scheduler: RTL and testbench
=====================================

# enc_pack_scheduler

Sequencer for the sparse-HDC encoder's bank of binder packs (10 binders each). On a single start request it processes the packs one at a time:
- fetches the level hypervectors for the pack's features from level memory;
- fires that pack's `start_encoding`;
- waits out the binder latency;
- hands the pack's shifted hypervectors to the bundling accumulator under a valid/ready handshake.

It sits between the top-level encoder control and the binder-pack and bundler datapath.

## Interface
Parameters:
- `N_PACKS`, default 10: number of binder packs sequenced, minimum 1.
- `LVL_LAT`, default 1: cycles from `lvl_rd_en` to level data valid at the pack inputs, minimum 1.
- `BIND_LAT`, default 1: cycles from the `pack_start` pulse to `shifted_hv` valid, minimum 1.
- `PIDX_W`, default `$clog2(N_PACKS)` with a floor of 1: pack index width.

Ports:
- `clk`, input, 1: the only clock.
- `nrst`, input, 1: one clock; reset is synchronous and active-high.
- `start`, input, 1: encode request, sampled only while `ready`=1.
- `ready`, output, 1: scheduler idle and able to accept `start`.
- `done`, output, 1: one-cycle pulse after the last pack's accumulate handshake.
- `lvl_rd_en`, output, 1: level-memory read strobe, one cycle per pack.
- `lvl_rd_addr`, output, `PIDX_W`: pack index being fetched.
- `pack_start`, output, `N_PACKS`: one-hot, one-cycle `start_encoding` pulse to pack p.
- `acc_clr`, output, 1: one-cycle accumulator clear at the start of a job.
- `acc_valid`, output, 1: the selected pack's shifted HVs are valid for bundling.
- `acc_pack`, output, `PIDX_W`: pack index selecting the bundler input mux.
- `acc_ready`, input, 1: accumulator accepts the data.

## Operation
States are IDLE, FETCH, WAIT_LVL, BIND, WAIT_BIND, ACC and DONE. Two counters are used: `pidx` (0..N_PACKS-1) and `wcnt` (the wait counter).

- **IDLE:** `ready`=1. If `start`=1, clear `pidx` to 0 and go to FETCH.
- **FETCH:** `lvl_rd_en`=1 and `lvl_rd_addr`=`pidx`. `acc_clr`=1 only when `pidx`==0. Load `wcnt`=`LVL_LAT`-1 and go to WAIT_LVL.
- **WAIT_LVL:** decrement `wcnt`. Go to BIND when `wcnt`==0.
- **BIND:** `pack_start[pidx]`=1 and all other bits 0. Load `wcnt`=`BIND_LAT`-1 and go to WAIT_BIND.
- **WAIT_BIND:** decrement `wcnt`. Go to ACC when `wcnt`==0.
- **ACC:** `acc_valid`=1 and `acc_pack`=`pidx`, both held stable until `acc_ready`=1.
  - If the handshake completes and `pidx`==N_PACKS-1, go to DONE.
  - If the handshake completes otherwise, increment `pidx` and go to FETCH.
- **DONE:** `done`=1 for one cycle, then go to IDLE.

Boundary behaviour:
- `start` outside IDLE is ignored, not queued.
- `start` held high continuously restarts the job on the IDLE cycle after DONE.
- With `acc_ready` tied low, the block stalls indefinitely in ACC. No timeout.
- `pidx` never wraps: the DONE transition is taken instead of an increment past N_PACKS-1.
- With `N_PACKS`=1, a job is FETCH→…→ACC→DONE, and `acc_clr` coincides with the only FETCH.
- `nrst` asserted in any state forces IDLE on the next edge. The in-flight job is abandoned and no `done` is produced.

## Timing
- All outputs are decoded from registered state and counters. No combinational path from `start` or `acc_ready` to any output.
- Reset values:
  - `ready`=1;
  - `done`, `lvl_rd_en`, `acc_clr`, `acc_valid` = 0;
  - `pack_start` all zeros;
  - `lvl_rd_addr`, `acc_pack` = 0.
- Per-pack cost with `acc_ready`=1 is `3+LVL_LAT+BIND_LAT` cycles (5 at the defaults).
- Job latency from the `start`-sampling edge (cycle 0) to `done` is `N_PACKS*(3+LVL_LAT+BIND_LAT)+1` cycles. At the defaults `done` is high in cycle 51 and `ready` returns in cycle 52.
- `pack_start[p]` is asserted exactly `LVL_LAT+1` cycles after the matching `lvl_rd_en`.
- `acc_valid` first rises exactly `BIND_LAT+1` cycles after `pack_start`.

## Structure
- Shared encoder package:
  - `enc_sched_state_t` enum (7 states).
  - `N_PACKS` and binders-per-pack constants, alongside the existing `HV_DIM` and `SHIFTS`.
- Single module: FSM plus two counters. No sub-module is needed; the wait counter is inline.

## Test plan
- **Default parameters, `acc_ready`=1:** pulse `start` at cycle 0.
  - `acc_clr` and `lvl_rd_en` (addr 0) in cycle 1;
  - `pack_start`=0x001 in cycle 3;
  - `acc_valid` with pack 0 in cycle 5;
  - `pack_start`=0x200 in cycle 48;
  - `done` in cycle 51, `ready` in cycle 52.
- **Backpressure:** hold `acc_ready`=0 for 4 cycles during pack 2's ACC. `acc_valid` and `acc_pack`=2 stay stable throughout, and `done` moves to cycle 55.
- **`start` pulsed in cycles 2, 10 and 51 during a job:** ignored; exactly one `done`, and `acc_clr` asserted only once.
- **Reset in cycle 20:** from cycle 21 `ready`=1 and all strobes are 0, with no `done`. A new `start` then restarts from pack 0 with `acc_clr`.
- **`N_PACKS`=1, `LVL_LAT`=3, `BIND_LAT`=2, `start` at cycle 0:**
  - FETCH in cycle 1, `pack_start`=1 in cycle 5;
  - `acc_valid` in cycle 8, `done` in cycle 9.
- **`start` held high:** back-to-back jobs, with `ready` high for exactly one cycle between `done` and the next `acc_clr`.

Source files
------------

// File: rtl/enc_pack_scheduler_pkg.sv
// Shared encoder definitions: scheduler state encoding and array geometry
// used by the binder-pack sequencer and the surrounding datapath.
package enc_pack_scheduler_pkg;

  localparam int HV_DIM           = 1024;
  localparam int SHIFTS           = 10;
  localparam int BINDERS_PER_PACK = 10;
  localparam int ENC_N_PACKS      = 10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_LVL  = 3'd2,
    S_BIND      = 3'd3,
    S_WAIT_BIND = 3'd4,
    S_ACC       = 3'd5,
    S_DONE      = 3'd6
  } enc_sched_state_t;

endpackage

// File: rtl/enc_pack_scheduler.sv
// Walks the binder packs one at a time: level fetch, bind pulse, binder
// latency wait, then a valid/ready hand-off to the bundling accumulator.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a start request
// S_FETCH     | level-memory read for pack pidx; accumulator clear on pack 0
// S_WAIT_LVL  | waiting out the level-memory latency
// S_BIND      | one-hot start_encoding pulse to pack pidx
// S_WAIT_BIND | waiting out the binder latency
// S_ACC       | offering pack pidx to the bundler until accepted
// S_DONE      | one-cycle completion pulse
module enc_pack_scheduler
  import enc_pack_scheduler_pkg::*;
#(
  parameter int N_PACKS  = ENC_N_PACKS,
  parameter int LVL_LAT  = 1,
  parameter int BIND_LAT = 1,
  parameter int PIDX_W   = (N_PACKS > 1) ? $clog2(N_PACKS) : 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  output logic               ready,
  output logic               done,
  output logic               lvl_rd_en,
  output logic [PIDX_W-1:0]  lvl_rd_addr,
  output logic [N_PACKS-1:0] pack_start,
  output logic               acc_clr,
  output logic               acc_valid,
  output logic [PIDX_W-1:0]  acc_pack,
  input  logic               acc_ready
);

  localparam int MAX_LAT = (LVL_LAT > BIND_LAT) ? LVL_LAT : BIND_LAT;
  localparam int WCNT_W  = $clog2(MAX_LAT + 1);

  localparam logic [WCNT_W-1:0] LVL_INIT  = WCNT_W'(LVL_LAT - 1);
  localparam logic [WCNT_W-1:0] BIND_INIT = WCNT_W'(BIND_LAT - 1);
  localparam logic [PIDX_W-1:0] LAST_PIDX = PIDX_W'(N_PACKS - 1);

  enc_sched_state_t  state_q, state_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= S_IDLE;
      pidx_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pidx_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        wcnt_d  = LVL_INIT;
        state_d = S_WAIT_LVL;
      end
      S_WAIT_LVL: begin
        if (wcnt_q == '0) state_d = S_BIND;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_BIND: begin
        wcnt_d  = BIND_INIT;
        state_d = S_WAIT_BIND;
      end
      S_WAIT_BIND: begin
        if (wcnt_q == '0) state_d = S_ACC;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      S_ACC: begin
        // The last pack finishes the job instead of advancing pidx.
        if (acc_ready) begin
          if (pidx_q == LAST_PIDX) begin
            state_d = S_DONE;
          end else begin
            pidx_d  = pidx_q + PIDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state so start/acc_ready never
  // reach an output combinationally.
  always_comb begin
    ready       = 1'b0;
    done        = 1'b0;
    lvl_rd_en   = 1'b0;
    lvl_rd_addr = '0;
    pack_start  = '0;
    acc_clr     = 1'b0;
    acc_valid   = 1'b0;
    acc_pack    = '0;
    unique case (state_q)
      S_IDLE:  ready = 1'b1;
      S_FETCH: begin
        lvl_rd_en   = 1'b1;
        lvl_rd_addr = pidx_q;
        acc_clr     = (pidx_q == '0);
      end
      S_BIND:  pack_start = N_PACKS'(1) << pidx_q;
      S_ACC: begin
        acc_valid = 1'b1;
        acc_pack  = pidx_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// Directed bench for enc_pack_scheduler: default-parameter jobs with
// backpressure, ignored starts, mid-job reset and back-to-back starts,
// plus a single-pack instance with longer latencies.
module tb_enc_pack_scheduler;

  logic clk = 1'b0;
  logic nrst;
  logic start0, acc_ready0;
  logic start1, acc_ready1;

  logic       ready0, done0, lvl_rd_en0, acc_clr0, acc_valid0;
  logic [3:0] lvl_rd_addr0, acc_pack0;
  logic [9:0] pack_start0;

  logic       ready1, done1, lvl_rd_en1, acc_clr1, acc_valid1;
  logic [0:0] lvl_rd_addr1, acc_pack1, pack_start1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  enc_pack_scheduler u0 (
    .clk(clk), .nrst(nrst), .start(start0), .ready(ready0), .done(done0),
    .lvl_rd_en(lvl_rd_en0), .lvl_rd_addr(lvl_rd_addr0), .pack_start(pack_start0),
    .acc_clr(acc_clr0), .acc_valid(acc_valid0), .acc_pack(acc_pack0),
    .acc_ready(acc_ready0)
  );

  enc_pack_scheduler #(.N_PACKS(1), .LVL_LAT(3), .BIND_LAT(2)) u1 (
    .clk(clk), .nrst(nrst), .start(start1), .ready(ready1), .done(done1),
    .lvl_rd_en(lvl_rd_en1), .lvl_rd_addr(lvl_rd_addr1), .pack_start(pack_start1),
    .acc_clr(acc_clr1), .acc_valid(acc_valid1), .acc_pack(acc_pack1),
    .acc_ready(acc_ready1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected default-instance outputs at job-relative cycle rel; pack 2's
  // ACC is stretched by s stall cycles and later packs shift by s.
  task automatic check_u0(input int rel, input int s);
    logic       e_lvl, e_av, e_done, e_ready, e_clr;
    logic [3:0] e_addr, e_pack;
    logic [9:0] e_ps;
    int f;
    int done_c;
    done_c  = 51 + s;
    e_lvl   = 1'b0; e_av = 1'b0; e_addr = '0; e_pack = '0; e_ps = '0;
    e_done  = (rel == done_c);
    e_ready = (rel > done_c);
    e_clr   = (rel == 1);
    for (int p = 0; p < 10; p++) begin
      f = 1 + 5 * p + ((p > 2) ? s : 0);
      if (rel == f) begin
        e_lvl  = 1'b1;
        e_addr = 4'(p);
      end
      if (rel == f + 2) e_ps = 10'(1) << p;
      if (rel >= f + 4 && rel <= f + 4 + ((p == 2) ? s : 0)) begin
        e_av   = 1'b1;
        e_pack = 4'(p);
      end
    end
    chk("u0.ready",       32'(ready0),       32'(e_ready));
    chk("u0.done",        32'(done0),        32'(e_done));
    chk("u0.lvl_rd_en",   32'(lvl_rd_en0),   32'(e_lvl));
    chk("u0.lvl_rd_addr", 32'(lvl_rd_addr0), 32'(e_addr));
    chk("u0.pack_start",  32'(pack_start0),  32'(e_ps));
    chk("u0.acc_clr",     32'(acc_clr0),     32'(e_clr));
    chk("u0.acc_valid",   32'(acc_valid0),   32'(e_av));
    chk("u0.acc_pack",    32'(acc_pack0),    32'(e_pack));
  endtask

  task automatic run_job(input int s, input bit extra_starts);
    acc_ready0 = 1'b1;
    start0     = 1'b1;
    cyc        = 0;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 200; k++) begin
      check_u0(cyc, s);
      if (cyc >= 52 + s) break;
      acc_ready0 = !(s > 0 && cyc >= 15 && cyc < 15 + s);
      start0     = extra_starts && (cyc == 2 || cyc == 10 || cyc == 51);
      tick();
    end
    start0     = 1'b0;
    acc_ready0 = 1'b1;
  endtask

  initial begin
    int nready;
    nrst = 1'b1; start0 = 1'b0; acc_ready0 = 1'b1; start1 = 1'b0; acc_ready1 = 1'b1;
    tick();
    tick();
    nrst = 1'b0;
    tick();

    chk("rst.ready",       32'(ready0),       32'd1);
    chk("rst.done",        32'(done0),        32'd0);
    chk("rst.lvl_rd_en",   32'(lvl_rd_en0),   32'd0);
    chk("rst.lvl_rd_addr", 32'(lvl_rd_addr0), 32'd0);
    chk("rst.pack_start",  32'(pack_start0),  32'd0);
    chk("rst.acc_clr",     32'(acc_clr0),     32'd0);
    chk("rst.acc_valid",   32'(acc_valid0),   32'd0);
    chk("rst.acc_pack",    32'(acc_pack0),    32'd0);
    chk("rst.u1_ready",    32'(ready1),       32'd1);

    // Plain job, then backpressure on pack 2, then ignored starts.
    run_job(0, 1'b0);
    tick();
    run_job(4, 1'b0);
    tick();
    run_job(0, 1'b1);
    tick();

    // Reset during cycle 20 abandons the job with no done.
    start0 = 1'b1;
    cyc    = 0;
    tick();
    start0 = 1'b0;
    while (cyc < 20) tick();
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    chk("mrst.ready",      32'(ready0),      32'd1);
    chk("mrst.lvl_rd_en",  32'(lvl_rd_en0),  32'd0);
    chk("mrst.pack_start", 32'(pack_start0), 32'd0);
    chk("mrst.acc_clr",    32'(acc_clr0),    32'd0);
    chk("mrst.acc_valid",  32'(acc_valid0),  32'd0);
    chk("mrst.done",       32'(done0),       32'd0);
    for (int k = 0; k < 40; k++) begin
      tick();
      chk("mrst.idle_done",  32'(done0),  32'd0);
      chk("mrst.idle_ready", 32'(ready0), 32'd1);
    end
    run_job(0, 1'b0);
    tick();

    // start held high: second job follows after exactly one ready cycle.
    nready = 0;
    start0 = 1'b1;
    cyc    = 0;
    tick();
    for (int k = 0; k < 200; k++) begin
      if (cyc <= 52) check_u0(cyc, 0);
      else           check_u0(cyc - 52, 0);
      if (cyc >= 51 && cyc <= 53) nready += int'(ready0);
      if (cyc >= 104) break;
      tick();
    end
    chk("held.ready_gap", 32'(nready), 32'd1);
    start0 = 1'b0;
    tick();
    chk("held.stop_ready", 32'(ready0),     32'd1);
    chk("held.stop_fetch", 32'(lvl_rd_en0), 32'd0);
    tick();

    // Single pack, LVL_LAT=3, BIND_LAT=2.
    start1 = 1'b1;
    cyc    = 0;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk("u1.ready",       32'(ready1),       32'(cyc >= 10));
      chk("u1.done",        32'(done1),        32'(cyc == 9));
      chk("u1.lvl_rd_en",   32'(lvl_rd_en1),   32'(cyc == 1));
      chk("u1.acc_clr",     32'(acc_clr1),     32'(cyc == 1));
      chk("u1.pack_start",  32'(pack_start1),  32'(cyc == 5));
      chk("u1.acc_valid",   32'(acc_valid1),   32'(cyc == 8));
      chk("u1.lvl_rd_addr", 32'(lvl_rd_addr1), 32'd0);
      chk("u1.acc_pack",    32'(acc_pack1),    32'd0);
      if (cyc >= 11) break;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
